// File: rtl/serial_addsub_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: FSM encoding and
// the default datapath width used alongside the ALU.
package serial_addsub_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_addsub_ctrl_if.sv
// Request/response bundle between the CPU control unit (master) and the
// serial add/subtract unit (slave).
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = serial_addsub_ctrl_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, overflow
  );

endinterface

// File: rtl/serial_addsub_ctrl_fa.sv
// Team 1-bit full-adder cell; the only arithmetic element of the serial
// datapath.
module FullAdder_1Bit (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell reused for
// WIDTH cycles, with start/done handshake and registered result flags.
module serial_addsub_ctrl
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_addsub_ctrl_if.slave  bus_if
);

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
  logic [WIDTH-1:0]   res_sr_q, res_sr_d;
  logic               carry_q,  carry_d;
  logic               cmsb_q,   cmsb_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q,   cout_d;
  logic               ovf_q,    ovf_d;
  logic               done_q,   done_d;
  logic               fa_s;
  logic               fa_co;

  FullAdder_1Bit u_fa (
    .a_i  (a_sr_q[0]),
    .b_i  (b_sr_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // Subtraction is a + ~b + 1: operand B is inverted on load and carry seeded with sub.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    cmsb_d   = cmsb_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus_if.start) begin
          a_sr_d  = bus_if.a;
          b_sr_d  = bus_if.b ^ {WIDTH{bus_if.sub}};
          carry_d = bus_if.sub;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        res_sr_d = {fa_s, res_sr_q[WIDTH-1:1]};
        carry_d  = fa_co;
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cmsb_d  = carry_q;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        done_d   = 1'b1;
        result_d = res_sr_q;
        cout_d   = carry_q;
        ovf_d    = cmsb_q ^ carry_q;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      a_sr_q   <= {WIDTH{1'b0}};
      b_sr_q   <= {WIDTH{1'b0}};
      res_sr_q <= {WIDTH{1'b0}};
      carry_q  <= 1'b0;
      cmsb_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      cmsb_q   <= cmsb_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign bus_if.busy     = (state_q != ST_IDLE);
  assign bus_if.done     = done_q;
  assign bus_if.result   = result_q;
  assign bus_if.cout     = cout_q;
  assign bus_if.overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl: vector table plus handshake,
// reset-abort and back-to-back sequences.
module tb_serial_addsub_ctrl;

  localparam int W = 16;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  serial_addsub_ctrl_if #(.WIDTH(W)) bus_if ();

  serial_addsub_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one operation and waits for done; lat = rising edges from accept to done.
  task automatic run_op(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.sub   = s;
    bus_if.a     = av;
    bus_if.b     = bv;
    @(negedge clk);
    bus_if.start = 1'b0;
    lat = 0;
    check("busy_after_accept", 32'(bus_if.busy), 32'd1);
    while (bus_if.done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (bus_if.done !== 1'b1) begin
      check("done_timeout", 32'(bus_if.done), 32'd1);
    end
  endtask

  vec_t vecs[8];
  int   lat;
  int   done_cnt;
  int   low_cnt;
  int   last_done;
  int   gap_ok;

  initial begin
    vecs[0] = '{1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 16'h5555, 16'h5555, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

    tests = 0;
    fails = 0;
    bus_if.start = 1'b0;
    bus_if.sub   = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(bus_if.busy),     32'd0);
    check("rst_done",   32'(bus_if.done),     32'd0);
    check("rst_result", 32'(bus_if.result),   32'd0);
    check("rst_cout",   32'(bus_if.cout),     32'd0);
    check("rst_ovf",    32'(bus_if.overflow), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].sub, vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat),             32'd17);
      check($sformatf("vec%0d_result", i),  32'(bus_if.result),   32'(vecs[i].exp_res));
      check($sformatf("vec%0d_cout", i),    32'(bus_if.cout),     32'(vecs[i].exp_cout));
      check($sformatf("vec%0d_ovf", i),     32'(bus_if.overflow), 32'(vecs[i].exp_ovf));
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 32'(bus_if.done), 32'd0);
    end

    // A second start during RUN must be ignored.
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.sub = 1'b1; bus_if.a = 16'h8000; bus_if.b = 16'h0001;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) bus_if.start = 1'b0;
      if (k == 5) begin
        bus_if.start = 1'b1; bus_if.sub = 1'b0; bus_if.a = 16'h1234; bus_if.b = 16'h1111;
      end
      if (k == 6) bus_if.start = 1'b0;
      if (bus_if.done === 1'b1) done_cnt++;
    end
    check("ignore_done_count", 32'(done_cnt),          32'd1);
    check("ignore_result",     32'(bus_if.result),     32'h7FFF);
    check("ignore_ovf",        32'(bus_if.overflow),   32'd1);

    // Reset during RUN bit 7 aborts the operation.
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.sub = 1'b0; bus_if.a = 16'h1111; bus_if.b = 16'h2222;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) bus_if.start = 1'b0;
    end
    check("pre_rst_busy", 32'(bus_if.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy",   32'(bus_if.busy),     32'd0);
    check("abort_done",   32'(bus_if.done),     32'd0);
    check("abort_result", 32'(bus_if.result),   32'd0);
    check("abort_cout",   32'(bus_if.cout),     32'd0);
    check("abort_ovf",    32'(bus_if.overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_op(1'b0, 16'h0003, 16'h0004, lat);
    check("post_rst_result", 32'(bus_if.result), 32'h0007);
    check("post_rst_latency", 32'(lat), 32'd17);

    // start held high: back-to-back ops every 18 cycles, busy low one cycle between.
    @(negedge clk);
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.sub = 1'b0; bus_if.a = 16'h0001; bus_if.b = 16'h0002;
    done_cnt  = 0;
    low_cnt   = 0;
    last_done = -1;
    gap_ok    = 1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 39) bus_if.start = 1'b0;
      if (bus_if.done === 1'b1) begin
        if (last_done >= 0 && (k - last_done) != 18) gap_ok = 0;
        if (done_cnt == 0) check("b2b_first_done", 32'(k), 32'd17);
        last_done = k;
        done_cnt++;
      end
      if (k <= 52 && bus_if.busy !== 1'b1) low_cnt++;
    end
    check("b2b_done_count", 32'(done_cnt),      32'd3);
    check("b2b_gap_18",     32'(gap_ok),        32'd1);
    check("b2b_busy_low",   32'(low_cnt),       32'd2);
    check("b2b_result",     32'(bus_if.result), 32'h0003);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Bit-serial two's-complement add/subtract unit that time-shares a single 1-bit full-adder cell across WIDTH cycles.
- Provides a low-area alternative to the ripple adder for the ALU's slow path.
- Sequences operand shifting, carry storage, bit counting and a start/done handshake.
- Sits beside the ALU and is driven by the CPU control unit.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 2..32.
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle pulse; result, cout and overflow are valid from this cycle on.
- result  output  WIDTH  sum/difference, registered.
- cout  output  1  final carry out (for sub: 1 = no borrow).
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: asserting rst_n low immediately forces the following, regardless of clk:
  - state = IDLE;
  - all shift registers, carry FF and counter = 0;
  - busy = 0, done = 0, result = 0, cout = 0, overflow = 0.
- Reset mid-operation aborts the operation; no done pulse is produced afterwards.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - On start=1, latch A_sr = a, B_sr = b XOR {WIDTH{sub}}, carry = sub, cnt = 0, then go to RUN.
  - Otherwise stay in IDLE.
  - result, cout and overflow hold their last values.
- RUN, one bit per cycle:
  - The FA cell computes s and co from A_sr[0], B_sr[0] and carry.
  - A_sr and B_sr shift right by 1.
  - The result shift register shifts right with s inserted at the MSB.
  - carry <= co.
  - When cnt == WIDTH-1, capture c_msb_in = carry before the update.
  - cnt increments each cycle.
  - After exactly WIDTH RUN cycles (cnt == WIDTH-1 processed), go to DONE.
- DONE, one cycle:
  - done = 1.
  - result = result shift register, cout = carry, overflow = c_msb_in XOR carry.
  - Always returns to IDLE next cycle.
- Latency: start sampled at edge 0; done is high during the cycle after edge WIDTH+1. Total WIDTH+2 cycles start-to-idle.
- start while busy (RUN or DONE) is ignored; no queuing. Operands changing during RUN have no effect.
- start held high continuously produces back-to-back operations, each accepted in IDLE. Throughput is one operation per WIDTH+2 cycles.
- Arithmetic is modulo 2^WIDTH; no saturation.
- busy = (state != IDLE), registered-state decode with no combinational path from start.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10;
  - the default WIDTH of 16, shared with the ALU.
- One sub-module: the team's existing 1-bit full-adder cell (FullAdder_1Bit), instantiated once as the serial datapath.
- Everything else (FSM, counter, shift registers, carry FF) lives in serial_addsub_ctrl.

Test Plan:
- a=16'h1234, b=16'h4321, sub=0 -> done at cycle 17 after start edge; result=16'h5555, cout=0, overflow=0.
- a=16'h7FFF, b=16'h0001, sub=0 -> result=16'h8000, cout=0, overflow=1.
- a=16'hFFFF, b=16'h0001, sub=0 -> result=16'h0000, cout=1, overflow=0. Then a=16'h0000, b=16'h0001, sub=1 -> result=16'hFFFF, cout=0, overflow=0.
- a=16'h8000, b=16'h0001, sub=1 -> result=16'h7FFF, overflow=1. Pulse start again with different operands during RUN -> ignored; result unchanged and exactly one done pulse.
- Start an operation, drop rst_n low at RUN bit 7 -> outputs immediately 0 and state IDLE, with no done pulse. After release, a=16'h0003, b=16'h0004, sub=0 -> result=16'h0007.
- start held high for 40 cycles -> done pulses 18 cycles apart; busy low exactly one cycle between operations.
